// File: rtl/demux_1x8_scan_ctrl.sv
// rtl/demux_1x8_scan_ctrl.sv - word-to-channel sequencer driving a 1x8 demux
//
// Accepts one 8-bit word per in_valid/in_ready handshake and walks the set
// bits of its mask in ascending order. Each visited channel n is held for
// DWELL cycles with I = in_data[n] and s = n, so bit n appears on demux y[n].
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   word offered
//   in_data    word to serialise, bit n routes to channel n
//   in_mask    channel enable, bit n set means channel n is visited
//   in_ready   block can accept a word (IDLE)
//   I          demux data input, registered
//   s          demux select, registered
//   ch_strobe  high on the first cycle of each channel's dwell
//   busy       word in flight (DRIVE)
//   done       one-cycle pulse when a word is finished

module demux_1x8_scan_ctrl #(
  parameter int DWELL   = 1,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [7:0] in_mask,
  output logic       in_ready,
  output logic       I,
  output logic [2:0] s,
  output logic       ch_strobe,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_t             state_q;
  state_t             state_d;
  logic [7:0]         data_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] cnt_q;

  logic       accept;
  logic       dwell_end;
  logic [3:0] first_hit;
  logic [3:0] next_hit;
  logic       has_first;
  logic       has_next;
  logic [2:0] first_idx;
  logic [2:0] next_idx;

  // Lowest set bit of m whose index is >= floor. Returns {found, index}.
  // Scanning downward lets the last match win, which is the lowest index.
  // A floor of 8 yields no match, which is how channel 7 ends the word.
  function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] floor);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= floor)) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign dwell_end = (cnt_q == DWELL_LAST);

  assign first_hit = find_from(in_mask, 4'd0);
  assign next_hit  = find_from(mask_q, {1'b0, s} + 4'd1);
  assign has_first = first_hit[3];
  assign first_idx = first_hit[2:0];
  assign has_next  = next_hit[3];
  assign next_idx  = next_hit[2:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = has_first ? ST_DRIVE : ST_DONE;
        end
      end
      ST_DRIVE: begin
        if (dwell_end && !has_next) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = 1'b1;
      ST_DRIVE: busy     = 1'b1;
      ST_DONE:  done     = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  // Registered demux pins and word storage. I and s are computed one edge
  // ahead so the demux only ever sees clean, edge-aligned transitions.
  // s is left alone outside DRIVE so it keeps the last channel visited.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= 8'h00;
      mask_q    <= 8'h00;
      cnt_q     <= '0;
      s         <= 3'd0;
      I         <= 1'b0;
      ch_strobe <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          I         <= 1'b0;
          ch_strobe <= 1'b0;
          if (accept) begin
            data_q <= in_data;
            mask_q <= in_mask;
            cnt_q  <= '0;
            if (has_first) begin
              s         <= first_idx;
              I         <= in_data[first_idx];
              ch_strobe <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (dwell_end) begin
            cnt_q <= '0;
            if (has_next) begin
              s         <= next_idx;
              I         <= data_q[next_idx];
              ch_strobe <= 1'b1;
            end else begin
              I         <= 1'b0;
              ch_strobe <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            ch_strobe <= 1'b0;
          end
        end
        default: begin
          I         <= 1'b0;
          ch_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule
